bus_master_arbiter: RTL and testbench

//  Round-robin arbiter that shares the xSoc system bus between four masters; it grants exactly one

---
 rtl/bus_master_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_master_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing the system bus between four masters.
// Exactly one master owns the bus at a time. An optional hold limit lets
// a waiting master preempt an owner that has held the bus too long.
// All outputs are registered, so there is no combinational path from a
// request to a grant.
//
// state | meaning
// IDLE  | no grant asserted; the next edge grants the first requester found
// BUSY  | bus_owner holds the bus; release, handover, preemption or keep
module bus_master_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] bus_owner,
    output logic       bus_busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last cycle index a grant may reach before it can be preempted.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       grnt_n;

    logic [3:0]       req;
    logic [3:0]       others;
    logic             owner_req;
    logic             hold_expired;
    logic             any_found;
    logic [1:0]       any_idx;
    logic             oth_found;
    logic [1:0]       oth_idx;
    logic [1:0]       idx;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    assign m0_grnt_ = grnt_n[0];
    assign m1_grnt_ = grnt_n[1];
    assign m2_grnt_ = grnt_n[2];
    assign m3_grnt_ = grnt_n[3];

    // Round-robin search from ptr, over all requesters and over non-owners.
    always_comb begin
        owner_req    = req[bus_owner];
        others       = req & ~(4'b0001 << bus_owner);
        hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        any_found    = 1'b0;
        any_idx      = ptr;
        oth_found    = 1'b0;
        oth_idx      = ptr;
        idx          = '0;
        // Walk the search order backwards so the nearest hit to ptr wins.
        for (int j = 3; j >= 0; j--) begin
            idx = ptr + 2'(j);
            if (req[idx]) begin
                any_found = 1'b1;
                any_idx   = idx;
            end
            if (others[idx]) begin
                oth_found = 1'b1;
                oth_idx   = idx;
            end
        end
    end

    // Arbitration FSM with registered grants, owner, busy and hold counter.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= IDLE;
            grnt_n    <= 4'hF;
            bus_owner <= 2'd0;
            bus_busy  <= 1'b0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_found) begin
                        state     <= BUSY;
                        grnt_n    <= ~(4'b0001 << any_idx);
                        bus_owner <= any_idx;
                        bus_busy  <= 1'b1;
                        ptr       <= any_idx + 2'd1;
                        hold_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if ((!owner_req || hold_expired) && oth_found) begin
                        // Release or preemption with a waiter: direct handover.
                        grnt_n    <= ~(4'b0001 << oth_idx);
                        bus_owner <= oth_idx;
                        ptr       <= oth_idx + 2'd1;
                        hold_cnt  <= '0;
                    end else if (!owner_req) begin
                        // bus_owner keeps the last owner for the master mux.
                        state    <= IDLE;
                        grnt_n   <= 4'hF;
                        bus_busy <= 1'b0;
                        hold_cnt <= '0;
                    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grnt_n <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: two instances (hold limit 4 and no limit)
// share one request stream and are checked every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_bus_master_arbiter;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] req_n = 4'hF;

    logic [3:0] ga_n, gb_n;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_master_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset_(reset_),
        .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
        .m0_grnt_(ga_n[0]), .m1_grnt_(ga_n[1]), .m2_grnt_(ga_n[2]), .m3_grnt_(ga_n[3]),
        .bus_owner(owner_a), .bus_busy(busy_a)
    );

    bus_master_arbiter #(.MAX_HOLD(0), .CNT_W(5)) dut_b (
        .clk(clk), .reset_(reset_),
        .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
        .m0_grnt_(gb_n[0]), .m1_grnt_(gb_n[1]), .m2_grnt_(gb_n[2]), .m3_grnt_(gb_n[3]),
        .bus_owner(owner_b), .bus_busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: owner is -1 when the bus is free; held counts the
    // cycles the current grant has already lasted.
    int  hold_lim [2] = '{4, 0};
    int  m_owner  [2];
    int  m_last   [2];
    int  m_ptr    [2];
    int  m_held   [2];
    bit  started = 0;

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++)
            if (r[(p + j) % 4]) return (p + j) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] r;
        logic [3:0] oth;
        int k;
        r = ~req_n;
        if (!reset_) started = 1;
        for (int i = 0; i < 2; i++) begin
            if (!reset_) begin
                m_owner[i] = -1; m_last[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
            end else if (m_owner[i] < 0) begin
                k = first_req(r, m_ptr[i]);
                if (k >= 0) begin
                    m_owner[i] = k; m_last[i] = k; m_ptr[i] = (k + 1) % 4; m_held[i] = 1;
                end
            end else begin
                oth = r;
                oth[m_owner[i]] = 1'b0;
                k = first_req(oth, m_ptr[i]);
                if ((!r[m_owner[i]] || (hold_lim[i] != 0 && m_held[i] >= hold_lim[i])) && k >= 0) begin
                    m_owner[i] = k; m_last[i] = k; m_ptr[i] = (k + 1) % 4; m_held[i] = 1;
                end else if (!r[m_owner[i]]) begin
                    m_owner[i] = -1;
                end else begin
                    m_held[i] = m_held[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                int exp_g;
                exp_g = (m_owner[i] < 0) ? 15 : (15 & ~(1 << m_owner[i]));
                chk(i == 0 ? "grnt_a_model" : "grnt_b_model", i == 0 ? int'(ga_n) : int'(gb_n), exp_g);
                chk(i == 0 ? "owner_a_model" : "owner_b_model", i == 0 ? int'(owner_a) : int'(owner_b), m_last[i]);
                chk(i == 0 ? "busy_a_model" : "busy_b_model", i == 0 ? int'(busy_a) : int'(busy_b), m_owner[i] >= 0 ? 1 : 0);
            end
        end
    end

    initial begin
        int order[$];
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int cnt;
        int low;

        // T1: reset with all requests active.
        reset_ = 1'b0; req_n = 4'h0;
        step(3);
        chk("t1_grnt_reset", int'(ga_n), 15);
        chk("t1_busy_reset", int'(busy_a), 0);
        chk("t1_owner_reset", int'(owner_a), 0);
        reset_ = 1'b1;
        step();
        chk("t1_first_grant", int'(ga_n), 14);

        // T2: fairness without hold limit; each owner releases one cycle after its grant.
        reset_ = 1'b0; req_n = 4'h0;
        step();
        reset_ = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            low = -1;
            for (int b = 3; b >= 0; b--) if (!gb_n[b]) low = b;
            order.push_back(low);
            chk("t2_busy", int'(busy_b), 1);
            req_n = ~gb_n;
        end
        for (int s = 0; s < 5; s++) chk("t2_order", order[s], exp_ord[s]);

        // T3: release by m1 hands directly to waiting m3.
        reset_ = 1'b0; req_n = 4'hF;
        step();
        reset_ = 1'b1; req_n = 4'b1101;
        step();
        chk("t3_m1_owns", int'(ga_n), 13);
        req_n = 4'b0101;
        step();
        req_n = 4'b0111;
        step();
        chk("t3_handover_grnt", int'(ga_n), 7);
        chk("t3_handover_owner", int'(owner_a), 3);
        chk("t3_handover_busy", int'(busy_a), 1);

        // T4: preemption after 4 cycles with hold limit 4.
        reset_ = 1'b0; req_n = 4'hF;
        step();
        reset_ = 1'b1; req_n = 4'b1110;
        step();
        req_n = 4'b1010;
        cnt = 1;
        for (int s = 0; s < 10 && !ga_n[0]; s++) begin
            step();
            if (!ga_n[0]) cnt++;
        end
        chk("t4_hold_cycles", cnt, 4);
        chk("t4_preempt_grnt", int'(ga_n), 11);
        chk("t4_preempt_owner", int'(owner_a), 2);

        // T5: a sole requester is never preempted.
        reset_ = 1'b0; req_n = 4'hF;
        step();
        reset_ = 1'b1; req_n = 4'b1101;
        step();
        cnt = 0;
        for (int s = 0; s < 40; s++) begin
            if (!ga_n[1]) cnt++;
            step();
        end
        chk("t5_sole_owner_cycles", cnt, 40);

        // T6: reset mid-grant, then ptr order restarts from 0.
        reset_ = 1'b0; req_n = 4'hF;
        step();
        reset_ = 1'b1; req_n = 4'b1011;
        step();
        chk("t6_m2_owns", int'(ga_n), 11);
        reset_ = 1'b0;
        step();
        chk("t6_reset_grnt", int'(ga_n), 15);
        chk("t6_reset_owner", int'(owner_a), 0);
        reset_ = 1'b1; req_n = 4'b0011;
        step();
        chk("t6_regrant_grnt", int'(ga_n), 11);
        chk("t6_regrant_owner", int'(owner_a), 2);

        // Random request traffic with occasional resets, checked by the model.
        for (int s = 0; s < 2000; s++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) req_n[b] = ~req_n[b];
            reset_ = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
